rr_grant_arbiter: RTL and testbench

//  Round-robin arbiter for 4 requesters. Drives the 2-bit index + enable pair

---
 rtl/rr_grant_arbiter.sv | 66 ++++++
 tb/tb_rr_grant_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: 4-way round-robin arbiter with hold limit, drives a 2-to-4 grant decoder
module rr_grant_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] grant_idx,
  output logic       grant_en,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, idx_n, win, off;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0] dbl;
  logic [3:0] rot;
  logic en_n, to_n, at_max, rel;
  assign dbl = {req, req};
  assign rot = dbl[ptr +: 4];
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign win = ptr + off;
  assign at_max = cnt == CNT_W'(MAX_HOLD);
  assign rel = done | ~req[grant_idx] | at_max;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant_idx <= 2'd0;
      grant_en <= 1'b0;
      timeout <= 1'b0;
      ptr <= 2'd0;
      cnt <= '0;
    end else begin
      state <= state_n;
      grant_idx <= idx_n;
      grant_en <= en_n;
      timeout <= to_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    idx_n = grant_idx;
    en_n = grant_en;
    to_n = 1'b0;
    ptr_n = ptr;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        idx_n = win;
        en_n = 1'b1;
        cnt_n = CNT_W'(1);
      end
    end else if (rel) begin
      state_n = IDLE;
      en_n = 1'b0;
      ptr_n = grant_idx + 2'd1;
      cnt_n = '0;
      to_n = at_max & ~done & req[grant_idx];
    end else
      cnt_n = cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: randomized and directed checks against a cycle-level arbitration model
module tb_rr_grant_arbiter;
  localparam int MH = 8;
  logic clk = 1'b0, rst = 1'b1, done = 1'b0;
  logic [3:0] req = 4'd0;
  logic [1:0] grant_idx;
  logic grant_en, timeout;
  int n_tests = 0, n_fail = 0;
  int m_en, m_idx, m_to, m_ptr, m_cnt;
  rr_grant_arbiter #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_idx(grant_idx), .grant_en(grant_en), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_en = 0; m_idx = 0; m_to = 0; m_ptr = 0; m_cnt = 0;
  endtask
  task automatic model_edge(input logic [3:0] r, input logic d);
    bit found;
    if (m_en == 0) begin
      m_to = 0;
      if (r != 0) begin
        found = 0;
        for (int k = 0; k < 4; k++)
          if (!found && r[(m_ptr + k) % 4]) begin
            m_idx = (m_ptr + k) % 4;
            found = 1;
          end
        m_en = 1;
        m_cnt = 1;
      end
    end else if (d || !r[m_idx] || m_cnt == MH) begin
      m_to = (!d && r[m_idx]) ? 1 : 0;
      m_en = 0;
      m_ptr = (m_idx + 1) % 4;
      m_cnt = 0;
    end else begin
      m_cnt++;
      m_to = 0;
    end
  endtask
  task automatic step(input logic [3:0] r, input logic d);
    req = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    @(negedge clk);
    chk("grant_en", grant_en, m_en);
    chk("grant_idx", grant_idx, m_idx);
    chk("timeout", timeout, m_to);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    req = 4'd0;
    done = 1'b0;
    #1;
    chk("rst_en", grant_en, 0);
    chk("rst_idx", grant_idx, 0);
    chk("rst_to", timeout, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int n;
    logic [3:0] r;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("init_en", grant_en, 0);
    chk("init_idx", grant_idx, 0);
    // single request, then done release moves priority past owner 2
    step(4'b0100, 0);
    chk("single_idx", grant_idx, 2);
    chk("single_en", grant_en, 1);
    step(4'b0100, 1);
    chk("single_rel", grant_en, 0);
    step(4'b0101, 0);
    chk("wrap_idx", grant_idx, 0);
    step(4'b0101, 1);
    step(4'b0101, 0);
    chk("wrap_next", grant_idx, 2);
    // reset while granted drops outputs without a clock edge
    chk("pre_rst_en", grant_en, 1);
    do_reset();
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 0);
      chk("rot_owner", grant_idx, g % 4);
      step(4'b1111, 0);
      step(4'b1111, 1);
      chk("rot_gap", grant_en, 0);
    end
    do_reset();
    step(4'b0001, 0);
    n = 0;
    while (grant_en && n < 20) begin
      n++;
      step(4'b0001, 0);
    end
    chk("hold_len", n, MH);
    chk("timeout_pulse", timeout, 1);
    step(4'b0001, 0);
    chk("regrant_idx", grant_idx, 0);
    chk("regrant_en", grant_en, 1);
    chk("timeout_clr", timeout, 0);
    step(4'b0000, 1);
    step(4'b0010, 0);
    chk("sim_own", grant_idx, 1);
    step(4'b0000, 1);
    chk("sim_to", timeout, 0);
    chk("sim_rel", grant_en, 0);
    step(4'b0010, 1);
    step(4'b1111, 0);
    step(4'b0011, 0);
    step(4'b1010, 0);
    chk("nonown_idx", grant_idx, 1);
    for (int b = 0; b < 20; b++) begin
      r = 4'($urandom);
      for (int c = 0; c < 100; c++) begin
        if (b % 2 == 0) r = 4'($urandom);
        if ($urandom_range(0, 40) == 0) do_reset();
        else step(r, $urandom_range(0, 5) == 0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
